conv_ctrl_fsm_param: RTL and testbench
======================================

Name: conv_ctrl_fsm_param

Overview:
Parametrised top-level sequencer for the convolution datapath. It drives a single valid/ready input stream to load kernel words into the kernel data store (KDS) and input columns into the input data shift store (IDSS). It issues MAC/shift strobes and tracks x/y/output-channel-group loop counters. A PIPE_DEPTH-deep tag pipeline produces output_valid and output coordinates aligned with the datapath latency.

Parameters:
FEATURE_MAP_WIDTH, 1024, output columns per row (x range)
FEATURE_MAP_HEIGHT, 1024, output rows (y range)
OUTPUT_NB_CHANNELS, 64, total output channels
CH_PAR, 4, output channels computed in parallel; must divide OUTPUT_NB_CHANNELS (elaboration-time assertion)
KERNEL_SIZE, 3, kernel width; KERNEL_SIZE-1 columns preloaded per row
K_WORDS, 12, stream words per kernel-group load
I_WORDS, 4, stream words per input column
PIPE_DEPTH, 3, cycles from mac_en to result at ODS output; >=1

Ports:
clk  in  1  clock
arst_n_in  in  1  reset, asynchronous, active-low
start  in  1  begin layer; sampled only in IDLE
running  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the last output leaves the pipeline
con_valid  in  1  stream word valid
con_ready  out  1  stream word ready
kds_we  out  1  write the current word to KDS
kds_addr  out  clog2(K_WORDS)  KDS word index
idss_we  out  1  write the current word to IDSS staging
idss_addr  out  clog2(I_WORDS)  IDSS word index within column
idss_shift  out  1  shift staged column into IDSS window
mac_en  out  1  issue one output computation (CH_PAR channels)
ods_shift  out  1  shift output data store; equals the delayed valid
output_valid  out  1  result at ODS output is valid
output_x, output_y, output_ch  out  32 each  coordinates of valid result; output_ch = group*CH_PAR (base channel)

Behaviour:
- Word accepted = con_valid && con_ready. con_ready is high only in LOAD_K, LOAD_I, COMPUTE. con_valid while not ready is ignored.
- kds_we = accept in LOAD_K. idss_we = accept in LOAD_I/COMPUTE. Address = word counter wc.
- States and transitions:
  - IDLE: start -> LOAD_K; clear x, y, grp, wc.
  - LOAD_K: wc++ per accept; on accept with wc==K_WORDS-1: wc=0 -> LOAD_I, col=0.
  - LOAD_I (row preload): on last word of a column, idss_shift=1 that cycle and col++. After column KERNEL_SIZE-2 -> COMPUTE. If KERNEL_SIZE==1, LOAD_K/row end goes directly to COMPUTE.
  - COMPUTE: on last word of a column, idss_shift=1 and mac_en=1 in the same cycle, tagging (x,y,grp). Then:
    - !last_x: x++.
    - last_x && !last_y: x=0, y++ -> LOAD_I.
    - last_x && last_y && !last_grp: x=y=0, grp++ -> LOAD_K.
    - all last: -> DRAIN.
  - DRAIN: con_ready=0; wait until the pipeline is empty, then done=1 -> IDLE.
- Stalls: no con_valid means no progress; counters hold. Words need not be consecutive.
- Tag pipeline: PIPE_DEPTH stages of {valid,x,y,grp}, shifting every cycle in all states. output_valid/ods_shift/output_* = final stage. output_valid rises exactly PIPE_DEPTH cycles after mac_en. output_* hold their last value when invalid.
- Reset values (async, any state incl. mid-load): state=IDLE. All counters 0. Pipeline cleared. All outputs 0 (running, con_ready, done, strobes, output_*).
- start while running: ignored. start held high in the cycle done pulses: takes effect on the next cycle in IDLE.
- Counters 32-bit, no wrap beyond the parameter limits.

Decomposition:
- Package conv_ctrl_pkg: fsm_state enum (IDLE, LOAD_K, LOAD_I, COMPUTE, DRAIN), tag struct {x,y,grp}, derived constant NB_GROUPS = OUTPUT_NB_CHANNELS/CH_PAR.
- Sub-module tag_pipe: parametrised PIPE_DEPTH delay line for the valid + tag struct.

Test Plan:
Common configuration: W=4, H=2, CH=8, CH_PAR=4, KERNEL_SIZE=3, K_WORDS=3, I_WORDS=2, PIPE_DEPTH=2.
- Continuous con_valid, pulse start -> 54 accepted words. mac_en count 16. Order: (x0..3,y0,ch0), (x0..3,y1,ch0), ..., ch4. done exactly 2 cycles after the final mac_en. running falls the cycle after done.
- Random con_valid gaps (50%) -> identical output sequence and kds/idss write sequence to the continuous case; no strobes during gaps.
- Transfer trace -> kds_addr sequence 0,1,2 per group. Exactly 2 idss_shift without mac_en per row. Each mac_en coincides with idss_shift and idss_addr=1.
- Timing -> output_valid high exactly 2 cycles after each mac_en. Outputs stay valid while in LOAD_I/LOAD_K after row/group ends. ods_shift==output_valid.
- Assert arst_n_in low mid-COMPUTE (x=2,y=1) -> all outputs 0 immediately. New start re-runs from (0,0,ch0) with correct counts.
- start pulsed during LOAD_I and start held high through done -> no effect while running. A second full run begins on the cycle after done.

Source files
------------

// File: rtl/conv_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// conv_ctrl_pkg : shared types and helpers for the convolution sequencer
// rev 1.0
// ---------------------------------------------------------------------------
package conv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_K  = 3'd1,
    ST_LOAD_I  = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_DRAIN   = 3'd4
  } fsm_state_e;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] grp;
  } tag_t;

  // Address width for an n-entry store; never narrower than one bit.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned nb_groups(input int unsigned channels,
                                            input int unsigned par);
    return channels / par;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_ctrl_fsm_param_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// conv_ctrl_fsm_param_if : input stream handshake plus datapath strobes/tags
// rev 1.0
// ---------------------------------------------------------------------------
interface conv_ctrl_fsm_param_if
  import conv_ctrl_pkg::*;
#(
  parameter int unsigned K_WORDS = 12,
  parameter int unsigned I_WORDS = 4
);

  logic                          con_valid;
  logic                          con_ready;
  logic                          kds_we;
  logic [addr_w(K_WORDS)-1:0]    kds_addr;
  logic                          idss_we;
  logic [addr_w(I_WORDS)-1:0]    idss_addr;
  logic                          idss_shift;
  logic                          mac_en;
  logic                          ods_shift;
  logic                          output_valid;
  logic [31:0]                   output_x;
  logic [31:0]                   output_y;
  logic [31:0]                   output_ch;

  modport master (
    input  con_valid,
    output con_ready, kds_we, kds_addr, idss_we, idss_addr, idss_shift,
           mac_en, ods_shift, output_valid, output_x, output_y, output_ch
  );

  modport slave (
    output con_valid,
    input  con_ready, kds_we, kds_addr, idss_we, idss_addr, idss_shift,
           mac_en, ods_shift, output_valid, output_x, output_y, output_ch
  );

endinterface
`default_nettype wire

// File: rtl/tag_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tag_pipe : DEPTH-stage valid/tag delay line matching the MAC datapath
// rev 1.0
// ---------------------------------------------------------------------------
module tag_pipe
  import conv_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic clk,
  input  logic arst_n_in,
  input  logic in_valid,
  input  tag_t in_tag,
  output logic out_valid,
  output tag_t out_tag,
  output logic pending
);

  logic [DEPTH-1:0] vld;
  tag_t             tags [DEPTH];

  // Tags only advance behind a valid so the output holds its last result.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tags[i] <= '0;
      end
    end else begin
      vld[0] <= in_valid;
      if (in_valid) begin
        tags[0] <= in_tag;
      end
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) begin
          tags[i] <= tags[i-1];
        end
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_tag   = tags[DEPTH-1];

  // Results still in flight ahead of the output stage.
  if (DEPTH == 1) begin : g_no_pending
    assign pending = 1'b0;
  end else begin : g_pending
    assign pending = |vld[DEPTH-2:0];
  end

endmodule
`default_nettype wire

// File: rtl/conv_ctrl_fsm_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// conv_ctrl_fsm_param : loads kernels/columns from one stream, issues MACs
// and tracks x/y/channel-group loops; rev 1.0
// ---------------------------------------------------------------------------
module conv_ctrl_fsm_param
  import conv_ctrl_pkg::*;
#(
  parameter int unsigned FEATURE_MAP_WIDTH  = 1024,
  parameter int unsigned FEATURE_MAP_HEIGHT = 1024,
  parameter int unsigned OUTPUT_NB_CHANNELS = 64,
  parameter int unsigned CH_PAR             = 4,
  parameter int unsigned KERNEL_SIZE        = 3,
  parameter int unsigned K_WORDS            = 12,
  parameter int unsigned I_WORDS            = 4,
  parameter int unsigned PIPE_DEPTH         = 3
) (
  input  logic                  clk,
  input  logic                  arst_n_in,
  input  logic                  start,
  output logic                  running,
  output logic                  done,
  conv_ctrl_fsm_param_if.master bus
);

  localparam int unsigned NB_GROUPS    = nb_groups(OUTPUT_NB_CHANNELS, CH_PAR);
  localparam int unsigned KA_W         = addr_w(K_WORDS);
  localparam int unsigned IA_W         = addr_w(I_WORDS);
  localparam int unsigned PRELOAD_LAST = (KERNEL_SIZE >= 2) ? KERNEL_SIZE - 2 : 0;

  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_LOAD_K  = ST_LOAD_K;
  localparam logic [2:0] S_LOAD_I  = ST_LOAD_I;
  localparam logic [2:0] S_COMPUTE = ST_COMPUTE;
  localparam logic [2:0] S_DRAIN   = ST_DRAIN;
  // A 1-wide kernel needs no preloaded columns, so a new row computes at once.
  localparam logic [2:0] S_ROW_START = (KERNEL_SIZE == 1) ? S_COMPUTE : S_LOAD_I;

  if ((OUTPUT_NB_CHANNELS % CH_PAR) != 0) begin : g_bad_ch_par
    $error("CH_PAR must divide OUTPUT_NB_CHANNELS");
  end
  if (PIPE_DEPTH < 1) begin : g_bad_depth
    $error("PIPE_DEPTH must be at least 1");
  end

  logic [2:0]  state;
  logic [31:0] wc;
  logic [31:0] col;
  logic [31:0] x;
  logic [31:0] y;
  logic [31:0] grp;

  logic accept;
  logic last_k;
  logic last_i;
  logic last_col;
  logic last_x;
  logic last_y;
  logic last_grp;
  logic pending;
  tag_t cur_tag;
  tag_t out_tag;

  always_comb begin
    last_k   = (wc  == 32'(K_WORDS - 1));
    last_i   = (wc  == 32'(I_WORDS - 1));
    last_col = (col == 32'(PRELOAD_LAST));
    last_x   = (x   == 32'(FEATURE_MAP_WIDTH - 1));
    last_y   = (y   == 32'(FEATURE_MAP_HEIGHT - 1));
    last_grp = (grp == 32'(NB_GROUPS - 1));
  end

  assign running       = (state != S_IDLE);
  assign bus.con_ready = (state == S_LOAD_K) || (state == S_LOAD_I) ||
                         (state == S_COMPUTE);
  assign accept        = bus.con_valid && bus.con_ready;

  assign bus.kds_we     = accept && (state == S_LOAD_K);
  assign bus.kds_addr   = wc[KA_W-1:0];
  assign bus.idss_we    = accept && ((state == S_LOAD_I) || (state == S_COMPUTE));
  assign bus.idss_addr  = wc[IA_W-1:0];
  assign bus.idss_shift = bus.idss_we && last_i;
  assign bus.mac_en     = bus.idss_shift && (state == S_COMPUTE);

  assign done = (state == S_DRAIN) && !pending;

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state <= S_IDLE;
      wc    <= '0;
      col   <= '0;
      x     <= '0;
      y     <= '0;
      grp   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_LOAD_K;
            wc    <= '0;
            col   <= '0;
            x     <= '0;
            y     <= '0;
            grp   <= '0;
          end
        end
        S_LOAD_K: begin
          if (accept) begin
            if (last_k) begin
              wc    <= '0;
              col   <= '0;
              state <= S_ROW_START;
            end else begin
              wc <= wc + 32'd1;
            end
          end
        end
        S_LOAD_I: begin
          if (accept) begin
            if (last_i) begin
              wc <= '0;
              if (last_col) begin
                col   <= '0;
                state <= S_COMPUTE;
              end else begin
                col <= col + 32'd1;
              end
            end else begin
              wc <= wc + 32'd1;
            end
          end
        end
        S_COMPUTE: begin
          if (accept) begin
            if (last_i) begin
              wc <= '0;
              if (!last_x) begin
                x <= x + 32'd1;
              end else if (!last_y) begin
                x     <= '0;
                y     <= y + 32'd1;
                col   <= '0;
                state <= S_ROW_START;
              end else if (!last_grp) begin
                x     <= '0;
                y     <= '0;
                grp   <= grp + 32'd1;
                state <= S_LOAD_K;
              end else begin
                state <= S_DRAIN;
              end
            end else begin
              wc <= wc + 32'd1;
            end
          end
        end
        S_DRAIN: begin
          if (!pending) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cur_tag = '{x: x, y: y, grp: grp};

  tag_pipe #(
    .DEPTH(PIPE_DEPTH)
  ) u_tag_pipe (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .in_valid  (bus.mac_en),
    .in_tag    (cur_tag),
    .out_valid (bus.output_valid),
    .out_tag   (out_tag),
    .pending   (pending)
  );

  assign bus.ods_shift = bus.output_valid;
  assign bus.output_x  = out_tag.x;
  assign bus.output_y  = out_tag.y;
  assign bus.output_ch = 32'(out_tag.grp * CH_PAR);

endmodule
`default_nettype wire

// File: tb/tb_conv_ctrl_fsm_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_conv_ctrl_fsm_param : randomized-stream bench with a loop-nest reference
// rev 1.0
// ---------------------------------------------------------------------------
module tb_conv_ctrl_fsm_param;

  localparam int W   = 4;
  localparam int H   = 2;
  localparam int CH  = 8;
  localparam int CHP = 4;
  localparam int KS  = 3;
  localparam int KW  = 3;
  localparam int IW  = 2;
  localparam int PD  = 2;
  localparam int NG  = CH / CHP;
  localparam int TOTAL_MAC = W * H * NG;

  typedef struct {
    bit is_k;
    int addr;
    bit shift;
    bit mac;
  } wev_t;

  typedef struct {
    int x;
    int y;
    int c;
  } otag_t;

  logic clk = 1'b0;
  logic arst_n_in = 1'b0;
  logic start = 1'b0;
  logic running;
  logic done;

  conv_ctrl_fsm_param_if #(.K_WORDS(KW), .I_WORDS(IW)) bus ();

  conv_ctrl_fsm_param #(
    .FEATURE_MAP_WIDTH  (W),
    .FEATURE_MAP_HEIGHT (H),
    .OUTPUT_NB_CHANNELS (CH),
    .CH_PAR             (CHP),
    .KERNEL_SIZE        (KS),
    .K_WORDS            (KW),
    .I_WORDS            (IW),
    .PIPE_DEPTH         (PD)
  ) dut (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .start     (start),
    .running   (running),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  wev_t  exp_w[$];
  otag_t exp_o[$];
  int    n_words_tot;
  int    n_acc;
  int    n_mac;
  int    last_mac_cyc;
  int    cyc = 0;
  bit    mon_en = 1'b0;
  logic [PD-1:0] mac_hist;

  // Reference: the layer as plain loop nests over groups, rows and columns.
  task automatic reset_model();
    exp_w.delete();
    exp_o.delete();
    for (int g = 0; g < NG; g++) begin
      for (int k = 0; k < KW; k++) exp_w.push_back('{1'b1, k, 1'b0, 1'b0});
      for (int yy = 0; yy < H; yy++) begin
        for (int c = 0; c < KS - 1; c++)
          for (int w = 0; w < IW; w++) exp_w.push_back('{1'b0, w, (w == IW - 1), 1'b0});
        for (int xx = 0; xx < W; xx++) begin
          for (int w = 0; w < IW; w++) exp_w.push_back('{1'b0, w, (w == IW - 1), (w == IW - 1)});
          exp_o.push_back('{xx, yy, g * CHP});
        end
      end
    end
    n_words_tot  = exp_w.size();
    n_acc        = 0;
    n_mac        = 0;
    last_mac_cyc = -1000;
    mac_hist     = '0;
    mon_en       = 1'b1;
  endtask

  bit valid_en = 1'b0;
  bit gap_mode = 1'b0;

  initial begin
    bus.con_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.con_valid = valid_en && (!gap_mode || (($urandom % 2) == 1));
    end
  end

  logic  mon_acc;
  logic [7:0] mon_addr;
  wev_t  mon_ev;
  otag_t mon_ot;

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      mon_acc = bus.con_valid && bus.con_ready;
      if (!mon_acc) begin
        chk("gap_strobe", {bus.kds_we, bus.idss_we, bus.idss_shift, bus.mac_en}, 4'b0);
      end else begin
        n_acc++;
        mon_addr = bus.kds_we ? 8'(bus.kds_addr) : 8'(bus.idss_addr);
        if (exp_w.size() == 0) begin
          chk("extra_word", 1, 0);
        end else begin
          mon_ev = exp_w.pop_front();
          chk("word_event", {bus.kds_we, bus.idss_we, bus.idss_shift, bus.mac_en, mon_addr},
              {mon_ev.is_k, !mon_ev.is_k, mon_ev.shift, mon_ev.mac, 8'(mon_ev.addr)});
        end
      end
      if (bus.mac_en) begin
        n_mac++;
        if (n_mac == TOTAL_MAC) last_mac_cyc = cyc;
      end
      if (bus.output_valid || mac_hist[PD-1])
        chk("valid_latency", bus.output_valid, mac_hist[PD-1]);
      if (bus.output_valid || bus.ods_shift)
        chk("ods_shift", bus.ods_shift, bus.output_valid);
      if (bus.output_valid) begin
        if (exp_o.size() == 0) begin
          chk("extra_output", 1, 0);
        end else begin
          mon_ot = exp_o.pop_front();
          chk("out_coord", {bus.output_x, bus.output_y, bus.output_ch},
              {32'(mon_ot.x), 32'(mon_ot.y), 32'(mon_ot.c)});
        end
      end
      if (done) chk("done_cycle", 96'(cyc), 96'(last_mac_cyc + PD));
      mac_hist = {mac_hist[PD-2:0], bus.mac_en};
    end
  end

  task automatic run_layer(input bit skip_start, input bit poke_start, input bit hold_start);
    bit poked = 1'b0;
    bit got_done = 1'b0;
    if (!skip_start) begin
      @(negedge clk);
      #1;
      reset_model();
      start = 1'b1;
    end
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (poke_start && !poked && n_acc >= 5) begin
        start = 1'b1;
        poked = 1'b1;
      end else begin
        start = hold_start && (n_mac >= TOTAL_MAC);
      end
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end
    #1;
    chk("done_seen", got_done, 1'b1);
    chk("running_at_done", running, 1'b1);
    chk("word_count", n_acc, n_words_tot);
    chk("mac_count", n_mac, TOTAL_MAC);
    chk("outputs_left", exp_o.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk(tag, {running, done, bus.con_ready, bus.kds_we, bus.idss_we, bus.idss_shift,
              bus.mac_en, bus.ods_shift, bus.output_valid, bus.kds_addr, bus.idss_addr,
              (bus.output_x | bus.output_y | bus.output_ch)}, 96'b0);
  endtask

  initial begin
    bit hit;
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset_state");
    @(negedge clk);
    arst_n_in = 1'b1;
    valid_en  = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_after_reset", {running, bus.con_ready, done}, 3'b0);

    // Back-to-back stream.
    run_layer(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("running_falls", running, 1'b0);

    // Random stream gaps give the same sequence.
    gap_mode = 1'b1;
    run_layer(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("running_falls_gaps", running, 1'b0);
    gap_mode = 1'b0;

    // Asynchronous reset while computing x=2, y=1 of the first group.
    @(negedge clk);
    #1;
    reset_model();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      #1;
      if (n_mac >= 6) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reach_mid_compute", hit, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    mon_en    = 1'b0;
    arst_n_in = 1'b0;
    #1;
    check_all_zero("async_reset_outputs");
    repeat (2) @(negedge clk);
    arst_n_in = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_after_midreset", {running, bus.con_ready}, 2'b0);
    run_layer(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("running_falls_rerun", running, 1'b0);

    // Start poked mid-load and held through done: only the held one counts.
    run_layer(1'b0, 1'b1, 1'b1);
    reset_model();
    @(negedge clk);
    chk("idle_after_done", running, 1'b0);
    @(negedge clk);
    chk("restart_after_done", {running, bus.con_ready}, 2'b11);
    start = 1'b0;
    run_layer(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("running_falls_second", running, 1'b0);

    valid_en = 1'b0;
    mon_en   = 1'b0;
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
